debug_word_tx: RTL

- Transmit end of the BIP debug link.
- Accepts 16-bit accumulator words that the processor's control block pushes with a one-cycle write strobe, and buffers them in a small FIFO.
- Serializes each word as two 8N1 UART frames, low byte first, on the tx pin.
- The existing rx/start path stays in the receive-side debug unit; this block owns tx and tx_full.

---
 rtl/debug_word_tx_pkg.sv | 17 +
 rtl/word_fifo.sv | 72 +++++++
 rtl/debug_word_tx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/debug_word_tx_pkg.sv
// Shared definitions for the debug link transmit path.
// Holds the word/byte widths, the default bit period and the FSM
// state encoding used by debug_word_tx and its bench.
package debug_word_tx_pkg;

  localparam int DB_DEFAULT       = 16;   // a word is exactly two bytes
  localparam int BYTE_W           = 8;
  localparam int BAUD_DIV_DEFAULT = 5208; // 50 MHz / 9600 baud

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } tx_state_t;

endpackage

// File: rtl/word_fifo.sv
// Small word FIFO between the processor write strobe and the serializer.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (empties the FIFO)
//   wr, w_data  : push strobe and word; ignored while full
//   rd          : pop strobe; ignored while empty
//   r_data      : word at the head (valid while !empty)
//   empty, full : registered, exact occupancy flags
module word_fifo #(
  parameter int DB      = 16,
  parameter int FIFO_AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [DB-1:0] w_data,
  input  logic          rd,
  output logic [DB-1:0] r_data,
  output logic          empty,
  output logic          full
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [DB-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] w_ptr;
  logic [FIFO_AW-1:0] r_ptr;
  logic [FIFO_AW-1:0] w_ptr_nxt;
  logic [FIFO_AW-1:0] r_ptr_nxt;
  logic               wr_en;
  logic               rd_en;

  // The flags sampled before the edge gate both operations, so a write
  // into a full FIFO is dropped even if a pop happens on the same edge.
  assign wr_en     = wr & ~full;
  assign rd_en     = rd & ~empty;
  assign w_ptr_nxt = w_ptr + 1'b1;
  assign r_ptr_nxt = r_ptr + 1'b1;
  assign r_data    = mem[r_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[w_ptr] <= w_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      unique case ({wr_en, rd_en})
        2'b10: begin
          w_ptr <= w_ptr_nxt;
          empty <= 1'b0;
          full  <= (w_ptr_nxt == r_ptr);
        end
        2'b01: begin
          r_ptr <= r_ptr_nxt;
          full  <= 1'b0;
          empty <= (r_ptr_nxt == w_ptr);
        end
        2'b11: begin
          // occupancy unchanged, flags stay as they are
          w_ptr <= w_ptr_nxt;
          r_ptr <= r_ptr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/debug_word_tx.sv
// Transmit end of the BIP debug link. Buffers 16-bit words in a FIFO and
// sends each as two 8N1 frames, low byte first.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (abandons any frame)
//   wr_uart    : one-cycle write strobe; word taken unless tx_full
//   w_data     : word to send, sampled with wr_uart
//   tx         : registered serial line, idles high
//   tx_full    : FIFO full, writes dropped
//   tx_busy    : high from the low byte's start bit to the high byte's stop bit
//   tx_done    : one-cycle pulse when the high byte's stop bit completes
//   fsm_state  : current FSM state, for observation
// Handshake: wr_uart is a fire-and-forget strobe; the producer must watch
// tx_full, a word presented while tx_full=1 is lost.
module debug_word_tx
  import debug_word_tx_pkg::*;
#(
  parameter int DB       = DB_DEFAULT,       // must be 16
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT, // clk cycles per bit, >= 2
  parameter int FIFO_AW  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_uart,
  input  logic [DB-1:0] w_data,
  output logic          tx,
  output logic          tx_full,
  output logic          tx_busy,
  output logic          tx_done,
  output tx_state_t     fsm_state
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);

  logic [DB-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_rd;

  word_fifo #(
    .DB      (DB),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr_uart),
    .w_data (w_data),
    .rd     (fifo_rd),
    .r_data (fifo_data),
    .empty  (fifo_empty),
    .full   (tx_full)
  );

  tx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic          hi_sel, hi_sel_nxt;
  logic [DB-1:0] hold, hold_nxt;
  logic          tx_reg, tx_nxt;
  logic          done_reg, done_nxt;

  logic [BYTE_W-1:0] cur_byte;
  logic [2:0]        bit_inc;
  logic              bit_end;

  assign cur_byte = hi_sel ? hold[2*BYTE_W-1:BYTE_W] : hold[BYTE_W-1:0];
  assign bit_inc  = bit_idx + 3'd1;
  assign bit_end  = (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      hi_sel   <= 1'b0;
      hold     <= '0;
      tx_reg   <= 1'b1;
      done_reg <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      hi_sel   <= hi_sel_nxt;
      hold     <= hold_nxt;
      tx_reg   <= tx_nxt;
      done_reg <= done_nxt;
    end
  end

  // tx_nxt is the line level for the state being entered, so the register
  // output changes exactly on state/bit boundaries.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    hi_sel_nxt  = hi_sel;
    hold_nxt    = hold;
    tx_nxt      = 1'b1;
    done_nxt    = 1'b0;
    fifo_rd     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd    = 1'b1;
          hold_nxt   = fifo_data;
          hi_sel_nxt = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = ST_START;
          tx_nxt     = 1'b0;
        end
      end
      ST_START: begin
        tx_nxt = 1'b0;
        if (bit_end) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = ST_DATA;
          tx_nxt      = cur_byte[0];
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_DATA: begin
        tx_nxt = cur_byte[bit_idx];
        if (bit_end) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = ST_STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_idx_nxt = bit_inc;
            tx_nxt      = cur_byte[bit_inc];
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_STOP: begin
        tx_nxt = 1'b1;
        if (bit_end) begin
          cnt_nxt = '0;
          if (!hi_sel) begin
            hi_sel_nxt = 1'b1;
            state_nxt  = ST_START;
            tx_nxt     = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign tx        = tx_reg;
  assign tx_done   = done_reg;
  assign tx_busy   = (state != ST_IDLE);
  assign fsm_state = state;

endmodule
